// File: rtl/mem_port_arbiter_if.sv
// Requester-side port of the data memory arbiter: one transaction request
// plus its grant and read-return signals.
interface mem_port_arbiter_if;
    logic        req;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the data-side read/write ports of mem between the load/store unit
// (port 0, fixed priority) and a debug/loader master (port 1, aged).
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   m0,
    mem_port_arbiter_if.slave   m1,
    output logic [29:0]         r2_addr,
    input  logic [31:0]         r2_val,
    output logic                w_enable,
    output logic [29:0]         w_addr,
    output logic [31:0]         w_val,
    output logic [3:0]          byte_en
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]  wait_cnt_r;
    logic        rd_pend_r;
    logic        rd_owner_r;

    logic        win_valid_s;
    logic        win_sel_s;
    logic        win_we_s;
    logic [29:0] win_addr_s;
    logic [31:0] win_wdata_s;
    logic [3:0]  win_be_s;
    logic        m0_gnt_s;
    logic        m1_gnt_s;

    // Winner selection: aged port 1 first, then port 0, then port 1.
    always_comb begin
        win_valid_s = 1'b0;
        win_sel_s   = 1'b0;
        if (m1.req && (wait_cnt_r == MAX_WAIT_C)) begin
            win_valid_s = 1'b1;
            win_sel_s   = 1'b1;
        end else if (m0.req) begin
            win_valid_s = 1'b1;
            win_sel_s   = 1'b0;
        end else if (m1.req) begin
            win_valid_s = 1'b1;
            win_sel_s   = 1'b1;
        end else begin
            win_valid_s = 1'b0;
            win_sel_s   = 1'b0;
        end
    end

    // Steer the winning requester's transaction fields.
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = 30'd0;
        win_wdata_s = 32'd0;
        win_be_s    = 4'd0;
        if (win_sel_s) begin
            win_we_s    = m1.we;
            win_addr_s  = m1.addr;
            win_wdata_s = m1.wdata;
            win_be_s    = m1.be;
        end else begin
            win_we_s    = m0.we;
            win_addr_s  = m0.addr;
            win_wdata_s = m0.wdata;
            win_be_s    = m0.be;
        end
    end

    // Memory port drive; everything is zero when there is no winner.
    always_comb begin
        r2_addr  = 30'd0;
        w_enable = 1'b0;
        w_addr   = 30'd0;
        w_val    = 32'd0;
        byte_en  = 4'd0;
        if (win_valid_s && win_we_s) begin
            w_enable = 1'b1;
            w_addr   = win_addr_s;
            w_val    = win_wdata_s;
            byte_en  = win_be_s;
        end else if (win_valid_s) begin
            r2_addr  = win_addr_s;
        end else begin
            r2_addr  = 30'd0;
        end
    end

    assign m0_gnt_s  = win_valid_s & ~win_sel_s;
    assign m1_gnt_s  = win_valid_s & win_sel_s;
    assign m0.gnt    = m0_gnt_s;
    assign m1.gnt    = m1_gnt_s;

    // Read data is shared; rvalid tells each requester whether it is theirs.
    assign m0.rvalid = rd_pend_r & ~rd_owner_r;
    assign m1.rvalid = rd_pend_r & rd_owner_r;
    assign m0.rdata  = r2_val;
    assign m1.rdata  = r2_val;

    // Remember which requester issued the read that returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else if (win_valid_s && !win_we_s) begin
            rd_pend_r  <= 1'b1;
            rd_owner_r <= win_sel_s;
        end else begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= rd_owner_r;
        end
    end

    // Count consecutive denied cycles of port 1; dropping req or a grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (m1.req && !m1_gnt_s) begin
            if (wait_cnt_r < MAX_WAIT_C) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

endmodule
